// File: rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv
// Shared definitions for the TPL ADC capture sequencer: state encodings
// and the width of the exported state field.
package ad_ip_jesd204_tpl_adc_capture_pkg;

    localparam int STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } capture_state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv
// Bundle of control, link-side, DMA-side and status signals of the capture
// sequencer; the controller sees it through the slave modport.
interface ad_ip_jesd204_tpl_adc_capture_ctrl_if
    import ad_ip_jesd204_tpl_adc_capture_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int OCTETS_PER_BEAT = 4,
    parameter int COUNT_WIDTH     = 16
) ();

    logic                       ctrl_arm;
    logic                       ctrl_abort;
    logic                       ctrl_trig_en;
    logic [COUNT_WIDTH-1:0]     ctrl_length;
    logic                       trigger;
    logic                       link_valid;
    logic [OCTETS_PER_BEAT-1:0] link_sof;
    logic [NUM_CHANNELS-1:0]    in_valid;
    logic [NUM_CHANNELS-1:0]    enable;
    logic                       dma_ovf;
    logic [NUM_CHANNELS-1:0]    out_valid;
    logic                       status_busy;
    logic                       status_done;
    logic                       status_ovf;
    logic [STATE_WIDTH-1:0]     status_state;
    logic [COUNT_WIDTH-1:0]     beat_count;

    modport master (
        output ctrl_arm, ctrl_abort, ctrl_trig_en, ctrl_length, trigger,
               link_valid, link_sof, in_valid, enable, dma_ovf,
        input  out_valid, status_busy, status_done, status_ovf,
               status_state, beat_count
    );

    modport slave (
        input  ctrl_arm, ctrl_abort, ctrl_trig_en, ctrl_length, trigger,
               link_valid, link_sof, in_valid, enable, dma_ovf,
        output out_valid, status_busy, status_done, status_ovf,
               status_state, beat_count
    );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_cnt.sv
// Beat counter for the capture sequencer: holds the latched capture length,
// counts delivered beats (saturating) and flags the final beat of a capture.
module ad_ip_jesd204_tpl_adc_capture_cnt #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic                   incr,
    input  logic [COUNT_WIDTH-1:0] length,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   terminal
);

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] length_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= '0;
            length_q <= '0;
        end else if (load) begin
            count    <= '0;
            length_q <= length;
        end else if (incr && (count != '1)) begin
            count <= count + ONE;
        end
    end

    // A zero length means continuous capture, so it never terminates.
    assign terminal = (length_q != '0) && ((count + ONE) == length_q);

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Capture sequencer between the TPL ADC core and the DMA: arm, optional
// trigger wait, start-of-frame alignment and gating of per-channel valids.
module ad_ip_jesd204_tpl_adc_capture_ctrl
    import ad_ip_jesd204_tpl_adc_capture_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int OCTETS_PER_BEAT = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input logic                            clk,
    input logic                            resetn,
    ad_ip_jesd204_tpl_adc_capture_ctrl_if.slave bus
);

    capture_state_t             state;
    capture_state_t             state_nxt;
    logic                       trigger_d;
    logic                       trig_rise;
    logic                       start;
    logic                       arm_accept;
    logic                       gate;
    logic                       done_set;
    logic                       done_q;
    logic                       ovf_q;
    logic                       cnt_terminal;
    logic [COUNT_WIDTH-1:0]     cnt_value;
    logic [OCTETS_PER_BEAT-1:0] sof_upper_unused;

    // Only octet position 0 marks a frame boundary usable as capture start.
    assign sof_upper_unused = bus.link_sof;
    assign start            = bus.link_valid & bus.link_sof[0];
    assign trig_rise        = bus.trigger & ~trigger_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            trigger_d <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            trigger_d <= bus.trigger;
            if (arm_accept) begin
                done_q <= 1'b0;
            end else if (done_set) begin
                done_q <= 1'b1;
            end
            if (arm_accept) begin
                ovf_q <= 1'b0;
            end else if (bus.dma_ovf && (state == ST_CAPTURE)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gate       = 1'b0;
        done_set   = 1'b0;
        arm_accept = bus.ctrl_arm & ~bus.ctrl_abort &
                     ((state == ST_IDLE) || (state == ST_DONE));
        case (state)
            ST_IDLE: begin
                if (arm_accept) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.ctrl_trig_en || trig_rise) state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (start) begin
                    gate = 1'b1;
                    if (cnt_terminal) begin
                        state_nxt = ST_DONE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                gate = 1'b1;
                if (bus.link_valid && cnt_terminal) begin
                    state_nxt = ST_DONE;
                    done_set  = 1'b1;
                end
            end
            ST_DONE: begin
                if (arm_accept) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything, but the beat in flight is still gated out.
        if (bus.ctrl_abort) begin
            state_nxt = ST_IDLE;
            done_set  = 1'b0;
        end
    end

    ad_ip_jesd204_tpl_adc_capture_cnt #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) i_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (arm_accept),
        .incr     (gate & bus.link_valid),
        .length   (bus.ctrl_length),
        .count    (cnt_value),
        .terminal (cnt_terminal)
    );

    assign bus.out_valid    = bus.in_valid & bus.enable & {NUM_CHANNELS{gate}};
    assign bus.status_busy  = (state == ST_ARMED) || (state == ST_ALIGN) ||
                              (state == ST_CAPTURE);
    assign bus.status_done  = done_q;
    assign bus.status_ovf   = ovf_q;
    assign bus.status_state = state;
    assign bus.beat_count   = cnt_value;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Scoreboard testbench for the capture sequencer: expected out_valid beats are
// queued by the stimulus and popped by a negedge monitor; status is checked directly.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
        .NUM_CHANNELS    (4),
        .OCTETS_PER_BEAT (4),
        .COUNT_WIDTH     (16)
    ) bus ();

    ad_ip_jesd204_tpl_adc_capture_ctrl #(
        .NUM_CHANNELS    (4),
        .OCTETS_PER_BEAT (4),
        .COUNT_WIDTH     (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    logic        s_arm, s_abort, s_trig_en, s_trigger, s_lv, s_ovf;
    logic [3:0]  s_sof, s_in, s_en;
    logic [15:0] s_len;
    logic [3:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic driveBus();
        bus.ctrl_arm     = s_arm;
        bus.ctrl_abort   = s_abort;
        bus.ctrl_trig_en = s_trig_en;
        bus.ctrl_length  = s_len;
        bus.trigger      = s_trigger;
        bus.link_valid   = s_lv;
        bus.link_sof     = s_sof;
        bus.in_valid     = s_in;
        bus.enable       = s_en;
        bus.dma_ovf      = s_ovf;
    endtask

    // One link cycle: drive staged inputs just after the edge and queue the gated beat.
    task automatic applyStimulus(input logic [3:0] exp_valid);
        @(posedge clk);
        #1;
        driveBus();
        if (exp_valid != 4'h0) exp_q.push_back(exp_valid);
        s_arm   = 1'b0;
        s_abort = 1'b0;
        s_ovf   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        else
            n_pass++;
    endtask

    initial begin
        logic [3:0] exp_v;
        s_arm = 0; s_abort = 0; s_trig_en = 0; s_trigger = 0; s_lv = 0; s_ovf = 0;
        s_sof = 4'h0; s_in = 4'hF; s_en = 4'hF; s_len = 16'd0;
        driveBus();

        fork
            forever begin
                @(negedge clk);
                if (bus.out_valid !== 4'h0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("[TB] FAIL out_valid_unexpected: got %b, required none", bus.out_valid);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (bus.out_valid !== exp_v)
                            $display("[TB] FAIL out_valid_beat: got %b, required %b", bus.out_valid, exp_v);
                        else
                            n_pass++;
                    end
                end
            end
        join_none

        #12;
        checkOutput("reset_state", bus.status_state, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_busy", bus.status_busy, 0);
        checkOutput("reset_done", bus.status_done, 0);
        checkOutput("reset_ovf", bus.status_ovf, 0);
        checkOutput("reset_beat_count", bus.beat_count, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        $display("[TB] length 4, no trigger");
        s_len = 16'd4; s_lv = 1; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        checkOutput("t1_armed", bus.status_state, 1);
        checkOutput("t1_busy", bus.status_busy, 1);
        applyStimulus(4'h0);
        s_sof = 4'b0010;
        applyStimulus(4'h0);
        s_sof = 4'b0001;
        applyStimulus(4'hF);
        s_sof = 4'b0000;
        applyStimulus(4'hF);
        checkOutput("t1_capture_state", bus.status_state, 3);
        checkOutput("t1_first_count", bus.beat_count, 1);
        applyStimulus(4'hF);
        applyStimulus(4'hF);
        applyStimulus(4'h0);
        checkOutput("t1_done_state", bus.status_state, 4);
        checkOutput("t1_done_flag", bus.status_done, 1);
        checkOutput("t1_beat_count", bus.beat_count, 4);
        checkOutput("t1_not_busy", bus.status_busy, 0);

        $display("[TB] trigger held high at arm");
        s_len = 16'd2; s_trig_en = 1; s_trigger = 1; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        checkOutput("t2_armed", bus.status_state, 1);
        checkOutput("t2_done_cleared", bus.status_done, 0);
        checkOutput("t2_count_cleared", bus.beat_count, 0);
        applyStimulus(4'h0);
        checkOutput("t2_still_armed", bus.status_state, 1);
        s_trigger = 0;
        applyStimulus(4'h0);
        s_trigger = 1;
        applyStimulus(4'h0);
        checkOutput("t2_armed_before_rise", bus.status_state, 1);
        applyStimulus(4'h0);
        checkOutput("t2_align_after_rise", bus.status_state, 2);
        s_sof = 4'b0001;
        applyStimulus(4'hF);
        s_sof = 4'b0000;
        applyStimulus(4'hF);
        applyStimulus(4'h0);
        checkOutput("t2_done_state", bus.status_state, 4);
        checkOutput("t2_beat_count", bus.beat_count, 2);

        $display("[TB] length 3 with a link gap");
        s_len = 16'd3; s_trig_en = 0; s_trigger = 0; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        s_sof = 4'b0001;
        applyStimulus(4'hF);
        s_sof = 4'b0000; s_lv = 0; s_in = 4'h0;
        applyStimulus(4'h0);
        checkOutput("t3_count_after_align", bus.beat_count, 1);
        s_lv = 1; s_in = 4'hF;
        applyStimulus(4'hF);
        checkOutput("t3_count_holds_on_gap", bus.beat_count, 1);
        applyStimulus(4'hF);
        applyStimulus(4'h0);
        checkOutput("t3_done_state", bus.status_state, 4);
        checkOutput("t3_beat_count", bus.beat_count, 3);

        $display("[TB] continuous capture then abort");
        s_len = 16'd0; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        s_sof = 4'b0001;
        applyStimulus(4'hF);
        s_sof = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                s_arm = 1;
                s_len = 16'd3;
            end
            applyStimulus(4'hF);
        end
        s_abort = 1;
        applyStimulus(4'hF);
        checkOutput("t4_count_before_abort", bus.beat_count, 10);
        s_ovf = 1;
        applyStimulus(4'h0);
        checkOutput("t4_idle_state", bus.status_state, 0);
        checkOutput("t4_done_clear", bus.status_done, 0);
        checkOutput("t4_beat_count", bus.beat_count, 11);
        applyStimulus(4'h0);
        checkOutput("t4_ovf_ignored_idle", bus.status_ovf, 0);

        $display("[TB] partial enables with DMA overflow");
        s_len = 16'd3; s_en = 4'b0101; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        s_sof = 4'b0001;
        applyStimulus(4'h5);
        s_sof = 4'b0000; s_ovf = 1;
        applyStimulus(4'h5);
        applyStimulus(4'h5);
        checkOutput("t5_ovf_set", bus.status_ovf, 1);
        applyStimulus(4'h0);
        checkOutput("t5_done_state", bus.status_state, 4);
        checkOutput("t5_ovf_sticky", bus.status_ovf, 1);
        checkOutput("t5_done_flag", bus.status_done, 1);
        s_en = 4'hF; s_len = 16'd5; s_arm = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        checkOutput("t5_ovf_cleared_by_arm", bus.status_ovf, 0);
        checkOutput("t5_done_cleared_by_arm", bus.status_done, 0);

        $display("[TB] reset during capture");
        s_sof = 4'b0001;
        applyStimulus(4'hF);
        s_sof = 4'b0000;
        applyStimulus(4'hF);
        checkOutput("t6_capture_state", bus.status_state, 3);
        applyStimulus(4'h0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("t6_async_out_valid", bus.out_valid, 0);
        checkOutput("t6_async_state", bus.status_state, 0);
        checkOutput("t6_async_count", bus.beat_count, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        s_arm = 1; s_abort = 1;
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        checkOutput("t6_arm_abort_idle", bus.status_state, 0);
        checkOutput("t6_arm_abort_not_busy", bus.status_busy, 0);
        applyStimulus(4'h0);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
